// File: rtl/dram_read_batch_scheduler.sv
// Batch read scheduler for one DRAM channel: buffers reads, then builds a timed ACT/PRE/RD
// schedule in a cycle-indexed memory. Optional macro SCHED_RD_EN_GATE_EN gates readback updates.
module dram_read_batch_scheduler #(
  parameter int unsigned BG_W     = 2,
  parameter int unsigned BANK_W   = 2,
  parameter int unsigned ROW_W    = 16,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned MAX_REQ  = 32,
  parameter int unsigned REQ_ID_W = 6,
  parameter int unsigned CYCLE_W  = 10,
  parameter int unsigned T_RCD    = 4,
  parameter int unsigned T_RP     = 4,
  parameter int unsigned T_CCD    = 4,
  parameter int unsigned T_RTP    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [BG_W-1:0]        req_bank_group,
  input  logic [BANK_W-1:0]      req_bank,
  input  logic [ROW_W-1:0]       req_row,
  input  logic [COL_W-1:0]       req_column,
  output logic                   req_ready,
  input  logic                   schedule_start,
  output logic                   schedule_done,
  output logic                   schedule_busy,
  input  logic                   sched_rd_en,
  input  logic [CYCLE_W-1:0]     sched_rd_cycle,
  output logic [2:0]             sched_cmd_type,
  output logic [BG_W-1:0]        sched_bank_group,
  output logic [BANK_W-1:0]      sched_bank,
  output logic [ROW_W-1:0]       sched_row,
  output logic [COL_W-1:0]       sched_column,
  output logic [REQ_ID_W-1:0]    sched_request_id,
  output logic [CYCLE_W-1:0]     sched_max_cycle,
  output logic [REQ_ID_W-1:0]    num_requests,
  output logic [REQ_ID_W-1:0]    num_srr_entries,
  output logic [REQ_ID_W-1:0]    num_sbr_entries,
  output logic [BG_W+BANK_W-1:0] critical_path_bank
);

  localparam int unsigned BID_W = BG_W + BANK_W;
  localparam int unsigned NB    = 2 ** BID_W;
  localparam int unsigned DEPTH = 2 ** CYCLE_W;
  localparam int unsigned IDX_W = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;
  localparam int unsigned EXT_W = CYCLE_W + 8;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_PRE = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]          cmd;
    logic [BID_W-1:0]    bank;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [REQ_ID_W-1:0] id;
  } entry_t;

  state_t              state;
  logic [REQ_ID_W-1:0] count;
  logic [BID_W-1:0]    buf_bank [MAX_REQ];
  logic [ROW_W-1:0]    buf_row  [MAX_REQ];
  logic [COL_W-1:0]    buf_col  [MAX_REQ];
  logic [MAX_REQ-1:0]  emitted;

  logic                has_cur;
  logic [BID_W-1:0]    cur_bank;
  logic [ROW_W-1:0]    cur_row;

  logic [NB-1:0]       bank_open, pre_v, rd_v;
  logic [ROW_W-1:0]    open_row [NB];
  logic [CYCLE_W-1:0]  pre_cyc  [NB];
  logic [CYCLE_W-1:0]  act_cyc  [NB];
  logic [CYCLE_W-1:0]  rd_cyc   [NB];
  logic                last_rd_v;
  logic [CYCLE_W-1:0]  last_rd_cyc;
  logic                has_prev;
  logic [CYCLE_W-1:0]  prev_cyc;
  logic [REQ_ID_W-1:0] bank_cnt [NB];

  logic [DEPTH-1:0]    sched_valid;
  entry_t              sched_mem [DEPTH];
  entry_t              rb;

  // Intake and per-accept statistics lookups
  logic [BID_W-1:0] req_bid;
  logic             accept;
  logic             row_dup;
  assign req_bid      = {req_bank_group, req_bank};
  assign req_ready    = (state == S_IDLE) && (count < REQ_ID_W'(MAX_REQ));
  assign accept       = req_valid && req_ready;
  assign num_requests = count;

  always_comb begin
    row_dup = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if ((REQ_ID_W'(i) < count) && (buf_bank[i] == req_bid) && (buf_row[i] == req_row))
        row_dup = 1'b1;
    end
  end

  // Busiest bank; strict compare keeps the lowest id on ties
  logic [BID_W-1:0]    crit_c;
  logic [REQ_ID_W-1:0] crit_cnt;
  always_comb begin
    crit_c   = '0;
    crit_cnt = bank_cnt[0];
    for (int b = 1; b < NB; b++) begin
      if (bank_cnt[b] > crit_cnt) begin
        crit_cnt = bank_cnt[b];
        crit_c   = BID_W'(b);
      end
    end
  end

  // Next request: oldest same bank+row, else oldest same bank, else oldest overall
  logic             any_f, bank_f, row_f;
  logic [IDX_W-1:0] any_i, bank_i, row_i, pick;
  always_comb begin
    any_f  = 1'b0;
    bank_f = 1'b0;
    row_f  = 1'b0;
    any_i  = '0;
    bank_i = '0;
    row_i  = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if ((REQ_ID_W'(i) < count) && !emitted[i]) begin
        any_f = 1'b1;
        any_i = IDX_W'(i);
        if (has_cur && (buf_bank[i] == cur_bank)) begin
          bank_f = 1'b1;
          bank_i = IDX_W'(i);
          if (buf_row[i] == cur_row) begin
            row_f = 1'b1;
            row_i = IDX_W'(i);
          end
        end
      end
    end
    pick = row_f ? row_i : (bank_f ? bank_i : any_i);
  end

  // Next command for the picked request and its earliest legal cycle
  logic [BID_W-1:0] pb;
  logic [ROW_W-1:0] pr;
  logic [2:0]       cmd;
  logic [EXT_W-1:0] base, bound, cand;
  logic             overflow;
  entry_t           new_entry;
  always_comb begin
    pb    = buf_bank[pick];
    pr    = buf_row[pick];
    base  = has_prev ? (EXT_W'(prev_cyc) + EXT_W'(1)) : '0;
    cand  = base;
    bound = '0;
    cmd   = CMD_ACT;
    if (bank_open[pb] && (open_row[pb] == pr)) begin
      cmd   = CMD_RD;
      bound = EXT_W'(act_cyc[pb]) + EXT_W'(T_RCD);
      if (bound > cand) cand = bound;
      bound = EXT_W'(last_rd_cyc) + EXT_W'(T_CCD);
      if (last_rd_v && (bound > cand)) cand = bound;
    end else if (bank_open[pb]) begin
      cmd   = CMD_PRE;
      bound = EXT_W'(rd_cyc[pb]) + EXT_W'(T_RTP);
      if (rd_v[pb] && (bound > cand)) cand = bound;
    end else begin
      bound = EXT_W'(pre_cyc[pb]) + EXT_W'(T_RP);
      if (pre_v[pb] && (bound > cand)) cand = bound;
    end
    overflow       = (cand >= EXT_W'(DEPTH));
    new_entry.cmd  = cmd;
    new_entry.bank = pb;
    new_entry.row  = (cmd == CMD_PRE) ? '0 : pr;
    new_entry.col  = (cmd == CMD_RD) ? buf_col[pick] : '0;
    new_entry.id   = (cmd == CMD_RD) ? REQ_ID_W'(pick) : '0;
  end

  logic mem_we;
  assign mem_we = rst_n && (state == S_GEN) && any_f && !overflow;

  // Data storage without reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_bank[count[IDX_W-1:0]] <= req_bid;
      buf_row[count[IDX_W-1:0]]  <= req_row;
      buf_col[count[IDX_W-1:0]]  <= req_column;
    end
    if (mem_we) sched_mem[cand[CYCLE_W-1:0]] <= new_entry;
  end

  // Control FSM, bank timing state and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      count              <= '0;
      emitted            <= '0;
      has_cur            <= 1'b0;
      cur_bank           <= '0;
      cur_row            <= '0;
      bank_open          <= '0;
      pre_v              <= '0;
      rd_v               <= '0;
      last_rd_v          <= 1'b0;
      last_rd_cyc        <= '0;
      has_prev           <= 1'b0;
      prev_cyc           <= '0;
      sched_valid        <= '0;
      schedule_done      <= 1'b0;
      schedule_busy      <= 1'b0;
      sched_max_cycle    <= '0;
      num_srr_entries    <= '0;
      num_sbr_entries    <= '0;
      critical_path_bank <= '0;
      for (int b = 0; b < NB; b++) begin
        open_row[b] <= '0;
        pre_cyc[b]  <= '0;
        act_cyc[b]  <= '0;
        rd_cyc[b]   <= '0;
        bank_cnt[b] <= '0;
      end
    end else begin
      schedule_done      <= 1'b0;
      critical_path_bank <= crit_c;
      case (state)
        S_IDLE: begin
          if (accept) begin
            count <= count + REQ_ID_W'(1);
            bank_cnt[req_bid] <= bank_cnt[req_bid] + REQ_ID_W'(1);
            if (!row_dup) num_srr_entries <= num_srr_entries + REQ_ID_W'(1);
            if (bank_cnt[req_bid] == '0) num_sbr_entries <= num_sbr_entries + REQ_ID_W'(1);
          end
          if (schedule_start) begin
            state         <= S_GEN;
            schedule_busy <= 1'b1;
          end
        end
        S_GEN: begin
          if (!any_f || overflow) begin
            state         <= S_DONE;
            schedule_busy <= 1'b0;
            schedule_done <= 1'b1;
            if (any_f) sched_max_cycle <= CYCLE_W'(DEPTH - 1);
          end else begin
            sched_valid[cand[CYCLE_W-1:0]] <= 1'b1;
            has_prev        <= 1'b1;
            prev_cyc        <= cand[CYCLE_W-1:0];
            sched_max_cycle <= cand[CYCLE_W-1:0];
            case (cmd)
              CMD_ACT: begin
                bank_open[pb] <= 1'b1;
                open_row[pb]  <= pr;
                act_cyc[pb]   <= cand[CYCLE_W-1:0];
              end
              CMD_PRE: begin
                bank_open[pb] <= 1'b0;
                pre_v[pb]     <= 1'b1;
                pre_cyc[pb]   <= cand[CYCLE_W-1:0];
              end
              default: begin
                rd_v[pb]      <= 1'b1;
                rd_cyc[pb]    <= cand[CYCLE_W-1:0];
                last_rd_v     <= 1'b1;
                last_rd_cyc   <= cand[CYCLE_W-1:0];
                emitted[pick] <= 1'b1;
                has_cur       <= 1'b1;
                cur_bank      <= pb;
                cur_row       <= pr;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Registered readback; unwritten entries read as all-zero NOP
  logic rd_upd;
`ifdef SCHED_RD_EN_GATE_EN
  assign rd_upd = sched_rd_en;
`else
  logic unused_rd_en;
  assign unused_rd_en = sched_rd_en;
  assign rd_upd       = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb <= '0;
    end else if (rd_upd) begin
      rb <= sched_valid[sched_rd_cycle] ? sched_mem[sched_rd_cycle] : '0;
    end
  end

  assign sched_cmd_type   = rb.cmd;
  assign sched_bank_group = rb.bank[BID_W-1:BANK_W];
  assign sched_bank       = rb.bank[BANK_W-1:0];
  assign sched_row        = rb.row;
  assign sched_column     = rb.col;
  assign sched_request_id = rb.id;

endmodule

// File: tb/tb_dram_read_batch_scheduler.sv
// Self-checking bench for dram_read_batch_scheduler: directed batches plus random batches
// compared against a leader/group schedule model and a bank open/closed read checker.
module tb_dram_read_batch_scheduler;

  localparam int BG_W = 2, BANK_W = 2, ROW_W = 16, COL_W = 10;
  localparam int MAX_REQ = 32, REQ_ID_W = 6, CYCLE_W = 10;
  localparam int T_RCD = 4, T_RP = 4, T_CCD = 4, T_RTP = 2;
  localparam int NB = 16, DEPTH = 1024;
  localparam int CMD_NOP = 0, CMD_ACT = 1, CMD_RD = 2, CMD_PRE = 3;

  logic                clk, rst_n;
  logic                req_valid, req_ready;
  logic [BG_W-1:0]     req_bank_group;
  logic [BANK_W-1:0]   req_bank;
  logic [ROW_W-1:0]    req_row;
  logic [COL_W-1:0]    req_column;
  logic                schedule_start, schedule_done, schedule_busy;
  logic                sched_rd_en;
  logic [CYCLE_W-1:0]  sched_rd_cycle;
  logic [2:0]          sched_cmd_type;
  logic [BG_W-1:0]     sched_bank_group;
  logic [BANK_W-1:0]   sched_bank;
  logic [ROW_W-1:0]    sched_row;
  logic [COL_W-1:0]    sched_column;
  logic [REQ_ID_W-1:0] sched_request_id;
  logic [CYCLE_W-1:0]  sched_max_cycle;
  logic [REQ_ID_W-1:0] num_requests, num_srr_entries, num_sbr_entries;
  logic [BG_W+BANK_W-1:0] critical_path_bank;

  dram_read_batch_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_bank_group(req_bank_group), .req_bank(req_bank),
    .req_row(req_row), .req_column(req_column), .req_ready(req_ready),
    .schedule_start(schedule_start), .schedule_done(schedule_done),
    .schedule_busy(schedule_busy), .sched_rd_en(sched_rd_en),
    .sched_rd_cycle(sched_rd_cycle), .sched_cmd_type(sched_cmd_type),
    .sched_bank_group(sched_bank_group), .sched_bank(sched_bank),
    .sched_row(sched_row), .sched_column(sched_column),
    .sched_request_id(sched_request_id), .sched_max_cycle(sched_max_cycle),
    .num_requests(num_requests), .num_srr_entries(num_srr_entries),
    .num_sbr_entries(num_sbr_entries), .critical_path_bank(critical_path_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request list and expected schedule
  int q_bank[$], q_row[$], q_col[$];
  int e_cmd[DEPTH], e_bank[DEPTH], e_row[DEPTH], e_col[DEPTH], e_id[DEPTH];
  int e_max, e_srr, e_sbr, e_crit;
  int m_prev;

  task automatic place(input int cmd, input int b, input int row, input int col,
                       input int id, input int lower);
    int c;
    c = m_prev + 1;
    if (lower > c) c = lower;
    m_prev = c;
    if (c < DEPTH) begin
      e_cmd[c] = cmd; e_bank[c] = b; e_row[c] = row; e_col[c] = col; e_id[c] = id;
    end
  endtask

  task automatic run_model();
    int n, left, lead, lb, lr, last_rd;
    bit done_r[MAX_REQ];
    bit open[NB];
    int orow[NB], tpre[NB], tact[NB], trd[NB], cnt[NB];
    n = q_bank.size();
    for (int c = 0; c < DEPTH; c++) begin
      e_cmd[c] = CMD_NOP; e_bank[c] = 0; e_row[c] = 0; e_col[c] = 0; e_id[c] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      open[b] = 0; orow[b] = 0; tpre[b] = -100; tact[b] = -100; trd[b] = -100; cnt[b] = 0;
    end
    for (int i = 0; i < MAX_REQ; i++) done_r[i] = 0;
    m_prev = -1; last_rd = -100; left = n; lead = 0;
    while (left > 0) begin
      lb = q_bank[lead]; lr = q_row[lead];
      for (int i = 0; i < n; i++) begin
        if (!done_r[i] && q_bank[i] == lb && q_row[i] == lr) begin
          if (open[lb] && orow[lb] != lr) begin
            place(CMD_PRE, lb, 0, 0, 0, trd[lb] + T_RTP);
            tpre[lb] = m_prev; open[lb] = 0;
          end
          if (!open[lb]) begin
            place(CMD_ACT, lb, lr, 0, 0, tpre[lb] + T_RP);
            tact[lb] = m_prev; open[lb] = 1; orow[lb] = lr;
          end
          place(CMD_RD, lb, 0, q_col[i], i,
                (tact[lb] + T_RCD > last_rd + T_CCD) ? tact[lb] + T_RCD : last_rd + T_CCD);
          trd[lb] = m_prev; last_rd = m_prev; done_r[i] = 1; left--;
        end
      end
      lead = -1;
      for (int i = 0; i < n; i++) if (lead < 0 && !done_r[i] && q_bank[i] == lb) lead = i;
      for (int i = 0; i < n; i++) if (lead < 0 && !done_r[i]) lead = i;
    end
    e_max = (m_prev < 0) ? 0 : m_prev;
    e_srr = 0; e_sbr = 0; e_crit = 0;
    for (int i = 0; i < n; i++) begin
      bit dup;
      dup = 0;
      for (int j = 0; j < i; j++) if (q_bank[j] == q_bank[i] && q_row[j] == q_row[i]) dup = 1;
      if (!dup) e_srr++;
      cnt[q_bank[i]]++;
    end
    for (int b = 0; b < NB; b++) begin
      if (cnt[b] > 0) e_sbr++;
      if (cnt[b] > cnt[e_crit]) e_crit = b;
    end
  endtask

  function automatic longint pack(input int cmd, input int b, input int row, input int col,
                                  input int id, input bit masked);
    longint r;
    r = (longint'(cmd) << 36) | (longint'(b) << 32);
    if (!masked || cmd == CMD_ACT) r = r | (longint'(row) << 16);
    if (!masked || cmd == CMD_RD) r = r | (longint'(col) << 6) | longint'(id);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; schedule_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_bank.delete(); q_row.delete(); q_col.delete();
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_ready"}, req_ready, 1);
    check({pfx, "_done"}, schedule_done, 0);
    check({pfx, "_busy"}, schedule_busy, 0);
    check({pfx, "_rb"}, pack(sched_cmd_type, {sched_bank_group, sched_bank}, sched_row,
                             sched_column, sched_request_id, 0), 0);
    check({pfx, "_max"}, sched_max_cycle, 0);
    check({pfx, "_nreq"}, num_requests, 0);
    check({pfx, "_srr"}, num_srr_entries, 0);
    check({pfx, "_sbr"}, num_sbr_entries, 0);
    check({pfx, "_crit"}, critical_path_bank, 0);
  endtask

  task automatic push(input int b, input int row, input int col);
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    req_valid = 1'b1;
    req_bank_group = 2'(b >> 2); req_bank = 2'(b & 3);
    req_row = 16'(row); req_column = 10'(col);
    @(negedge clk);
    req_valid = 1'b0;
    q_bank.push_back(b); q_row.push_back(row); q_col.push_back(col);
  endtask

  task automatic push_random(input int n);
    int banks[4];
    banks[0] = 0; banks[1] = 1; banks[2] = 5; banks[3] = 12;
    for (int i = 0; i < n; i++)
      push(banks[$urandom_range(0, 3)], 16'h100 + $urandom_range(0, 2), $urandom_range(0, 1023));
  endtask

  task automatic run_batch(input int exp_max);
    int n, last, rd_cnt, c, b;
    bit seen;
    bit chk_open[NB];
    n = q_bank.size();
    run_model();
    check("num_requests", num_requests, n);
    schedule_start = 1'b1;
    @(negedge clk);
    schedule_start = 1'b0;
    check("busy_in_gen", schedule_busy, 1);
    seen = 0;
    for (int w = 0; w < 4000 && !seen; w++) begin
      if (schedule_done) seen = 1;
      else @(negedge clk);
    end
    check("done_seen", seen, 1);
    check("max_cycle", sched_max_cycle, e_max);
    if (exp_max >= 0) check("max_cycle_plan", sched_max_cycle, exp_max);
    check("num_srr", num_srr_entries, e_srr);
    check("num_sbr", num_sbr_entries, e_sbr);
    check("crit_bank", critical_path_bank, e_crit);
    @(negedge clk);
    check("done_pulse", schedule_done, 0);
    check("busy_after", schedule_busy, 0);
    check("ready_in_done", req_ready, 0);
    last = (e_max + 3 > DEPTH - 1) ? DEPTH - 1 : e_max + 3;
    rd_cnt = 0;
    for (int k = 0; k < NB; k++) chk_open[k] = 0;
    for (int k = 0; k <= last + 1; k++) begin
      c = (k <= last) ? k : DEPTH - 1;
      sched_rd_cycle = 10'(c); sched_rd_en = 1'b1;
      @(negedge clk);
      b = {sched_bank_group, sched_bank};
      if (e_cmd[c] == CMD_NOP)
        check($sformatf("rb_nop@%0d", c), pack(sched_cmd_type, b, sched_row, sched_column,
                                                sched_request_id, 0), 0);
      else
        check($sformatf("rb@%0d", c),
              pack(sched_cmd_type, b, sched_row, sched_column, sched_request_id, 1),
              pack(e_cmd[c], e_bank[c], e_row[c], e_col[c], e_id[c], 1));
      if (sched_cmd_type == 3'(CMD_ACT)) begin
        check($sformatf("act_to_open@%0d", c), chk_open[b], 0);
        chk_open[b] = 1;
      end else if (sched_cmd_type == 3'(CMD_RD)) begin
        check($sformatf("rd_to_closed@%0d", c), chk_open[b], 1);
        rd_cnt++;
      end else if (sched_cmd_type == 3'(CMD_PRE)) begin
        chk_open[b] = 0;
      end
    end
    check("rd_count", rd_cnt, n);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; schedule_start = 1'b0; sched_rd_en = 1'b1;
    sched_rd_cycle = '0; req_bank_group = '0; req_bank = '0; req_row = '0; req_column = '0;

    do_reset();
    check_cleared("reset");

    push(0, 16'h200, 0); push(0, 16'h200, 8); push(0, 16'h200, 16);
    run_batch(12);

    do_reset();
    push(0, 10, 0); push(0, 11, 0);
    run_batch(14);

    do_reset();
    push(0, 100, 0); push(1, 200, 0); push(0, 100, 8); push(4, 300, 0);
    run_batch(18);

    do_reset();
    run_batch(0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      push_random($urandom_range(1, MAX_REQ - 1));
      run_batch(-1);
    end

    do_reset();
    push_random(MAX_REQ);
    check("full_ready", req_ready, 0);
    check("full_count", num_requests, MAX_REQ);
    run_batch(-1);

    do_reset();
    push_random(10);
    schedule_start = 1'b1;
    @(negedge clk);
    schedule_start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_gen_busy", schedule_busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_cleared("midrst");
    sched_rd_cycle = '0;
    @(negedge clk);
    check("midrst_rb0", pack(sched_cmd_type, {sched_bank_group, sched_bank}, sched_row,
                             sched_column, sched_request_id, 0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dram_read_batch_scheduler.md
Name: dram_read_batch_scheduler

Overview:
- Batch read scheduler for one DRAM channel.
- Accepts read requests into a buffer, then on command computes a legal ACT/PRE/RD command schedule for the whole batch.
- Stores the schedule in a cycle-indexed schedule memory that a host reads back one entry per clock.
- Also reports batch statistics: requests, unique rows, unique banks, busiest bank.

Parameters:
- BG_W, 2, bank-group address width
- BANK_W, 2, bank-within-group width; bank id = {bg,bank}, NB = 2^(BG_W+BANK_W)
- ROW_W, 16, row width
- COL_W, 10, column width
- MAX_REQ, 32, request buffer depth
- REQ_ID_W, 6, request id / count width (must hold MAX_REQ)
- CYCLE_W, 10, schedule cycle index width; schedule depth DEPTH = 2^CYCLE_W
- T_RCD, 4, ACT to RD same bank
- T_RP, 4, PRE to ACT same bank
- T_CCD, 4, RD to RD, any bank
- T_RTP, 2, RD to PRE same bank

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_bank_group  in  BG_W  request bank group
- req_bank  in  BANK_W  request bank
- req_row  in  ROW_W  request row
- req_column  in  COL_W  request column
- req_ready  out  1  buffer can accept
- schedule_start  in  1  begin scheduling
- schedule_done  out  1  one-cycle completion pulse
- schedule_busy  out  1  scheduling in progress
- sched_rd_en  in  1  readback enable (see Optional Feature)
- sched_rd_cycle  in  CYCLE_W  schedule cycle to read
- sched_cmd_type  out  3  0=NOP, 1=ACT, 2=RD, 3=PRE
- sched_bank_group  out  BG_W  command bank group
- sched_bank  out  BANK_W  command bank
- sched_row  out  ROW_W  row (ACT)
- sched_column  out  COL_W  column (RD)
- sched_request_id  out  REQ_ID_W  request id (RD)
- sched_max_cycle  out  CYCLE_W  cycle of last scheduled command
- num_requests  out  REQ_ID_W  requests buffered
- num_srr_entries  out  REQ_ID_W  unique (bank,row) pairs
- num_sbr_entries  out  REQ_ID_W  unique banks
- critical_path_bank  out  BG_W+BANK_W  bank with most requests

Behaviour:
Reset and state machine:
- Reset: all outputs 0, buffer empty, schedule memory all NOP (per-entry valid bits cleared), FSM IDLE.
- Reset mid-GEN aborts the batch and clears everything.
- FSM: IDLE -> GEN on schedule_start; GEN -> DONE when all requests are emitted. DONE holds until reset.
- In DONE, start and requests are ignored.

Request intake (IDLE only):
- req_ready = (state==IDLE) && count<MAX_REQ.
- Accept when req_valid && req_ready; the request id is its arrival index starting at 0.
- num_requests increments on each accept.

Start and busy:
- schedule_busy is high in GEN.
- schedule_done pulses exactly one cycle on entry to DONE.
- Start with 0 requests: done pulses the next cycle, sched_max_cycle=0, no commands.

Emission order:
- Leader = oldest unscheduled request.
- Emit all unscheduled requests to the leader's bank and row, in arrival order.
- Next leader = oldest unscheduled request to the same bank if one exists, else the oldest overall.

Per-request commands:
- Bank closed: ACT.
- Bank open to a different row: PRE, then ACT.
- Bank already open to the same row: nothing before the RD.
- Then RD.
- Banks stay open when scheduling moves to another bank.

Command cycle placement:
- Each command goes at cycle = max(previous command cycle + 1, timing bounds). The first command is at cycle 0.
- Timing bounds: ACT >= PRE(same bank) + T_RP; RD >= ACT(same bank) + T_RCD; RD >= last RD (any bank) + T_CCD; PRE >= last RD (same bank) + T_RTP.
- One command per cycle. Entries are written into the schedule memory at their cycle index.
- sched_max_cycle = cycle of the last command.
- Reaching a cycle >= DEPTH: stop and go to DONE, with sched_max_cycle = DEPTH-1.

Statistics (valid by done):
- num_srr_entries = distinct (bank,row) pairs.
- num_sbr_entries = distinct banks.
- critical_path_bank = bank with the most requests; ties go to the lowest bank id.

Readback:
- Registered, 1-cycle latency.
- Outputs reflect the sched_rd_cycle sampled at the previous clock edge.
- Unwritten entries, or sched_rd_cycle values outside the written range, read as NOP with all fields 0.

Optional Feature:
- Macro SCHED_RD_EN_GATE_EN.
- Defined: readback registers update only when sched_rd_en=1 and hold otherwise.
- Undefined: they update every cycle and sched_rd_en is ignored.

Test Plan:
- Row hits: 3 reqs BG0 B0 row 0x200, cols 0/8/16 -> stats 3,1,1, crit 0. Schedule: ACT@0, RD@4 id0, RD@8 id1, RD@12 id2; max 12.
- Row conflict: BG0 B0 row 10, then row 11 -> stats 2,2,1, crit 0. Schedule: ACT@0, RD@4, PRE@6, ACT@10, RD@14; max 14.
- Multi-bank: (0,0,100,0), (0,1,200,0), (0,0,100,8), (1,0,300,0) -> stats 4,3,3, crit 0. Schedule: ACT B0@0, RD id0@4, RD id2@8, ACT BG0B1@9, RD id1@13, ACT BG1B0@14, RD id3@18; max 18.
- Read checker: no RD to a closed bank, no ACT to an open bank; RD count == num_requests.
- Empty start -> done pulse, max 0, all NOP.
- Fill MAX_REQ -> req_ready low.
- Reset mid-GEN -> all outputs 0, req_ready high.
